// File: rtl/ga_inner_prod_arbiter_if.sv
// Bundle of requester, product-unit and control signals around the inner-product arbiter.
// The slave modport is the arbiter's view; master is the surrounding requesters and product unit.
interface ga_inner_prod_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int VEC_W = 128,
    parameter int RES_W = 16
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*VEC_W-1:0] req_vec1_flat;
    logic [N_REQ*VEC_W-1:0] req_vec2_flat;
    logic [N_REQ-1:0]       req_grant;
    logic                   ip_valid_pls;
    logic [VEC_W-1:0]       ip_vec1;
    logic [VEC_W-1:0]       ip_vec2;
    logic                   ip_done_pls;
    logic [RES_W-1:0]       ip_res;
    logic [N_REQ-1:0]       rsp_valid_pls;
    logic [RES_W-1:0]       rsp_res;
    logic                   flush_req_pls;
    logic                   flush_done_pls;
    logic                   busy;
    logic                   err_sticky;

    modport slave (
        input  req_valid, req_vec1_flat, req_vec2_flat, ip_done_pls, ip_res, flush_req_pls,
        output req_grant, ip_valid_pls, ip_vec1, ip_vec2, rsp_valid_pls, rsp_res,
               flush_done_pls, busy, err_sticky
    );

    modport master (
        output req_valid, req_vec1_flat, req_vec2_flat, ip_done_pls, ip_res, flush_req_pls,
        input  req_grant, ip_valid_pls, ip_vec1, ip_vec2, rsp_valid_pls, rsp_res,
               flush_done_pls, busy, err_sticky
    );
endinterface

// File: rtl/ga_inner_prod_arbiter.sv
// Round-robin arbiter sharing one pipelined inner-product unit between N_REQ requesters.
// Each issue is tagged with its requester ID in an in-order FIFO so results route back to the owner.
module ga_inner_prod_arbiter #(
    parameter int N_REQ   = 4,
    parameter int VEC_W   = 128,
    parameter int RES_W   = 16,
    parameter int MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sw_rst,
    ga_inner_prod_arbiter_if.slave bus
);
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    localparam logic [ID_W-1:0]  RR_RST   = ID_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             ip_valid_q, ip_valid_d;
    logic [VEC_W-1:0] ip_vec1_q, ip_vec1_d;
    logic [VEC_W-1:0] ip_vec2_q, ip_vec2_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [RES_W-1:0] rsp_res_q, rsp_res_d;
    logic             err_q, err_d;
    logic [ID_W-1:0]  id_mem_q [MAX_OUT];

    logic             grant_en;
    logic             grant_hit;
    logic [ID_W-1:0]  grant_idx;
    logic [N_REQ-1:0] grant_vec;
    logic             push;
    logic             pop;
    logic             flush_done;

    // Search starts one past the last winner so every requester gets a turn.
    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant_en  = !sw_rst && (state_q == ST_RUN) && (count_q < CNT_MAX);
        grant_hit = 1'b0;
        grant_idx = rr_ptr_q;
        for (int k = 1; k <= N_REQ; k++) begin
            if (grant_en && !grant_hit && bus.req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
                grant_hit = 1'b1;
                grant_idx = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            end
        end
        grant_vec = grant_hit ? (N_REQ'(1) << grant_idx) : '0;
    end

    assign push = grant_hit;
    assign pop  = bus.ip_done_pls && (count_q != '0);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = push ? grant_idx : rr_ptr_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ip_valid_d  = push;
        ip_vec1_d   = ip_vec1_q;
        ip_vec2_d   = ip_vec2_q;
        rsp_valid_d = '0;
        rsp_res_d   = rsp_res_q;
        err_d       = err_q || (bus.ip_done_pls && (count_q == '0));
        flush_done  = 1'b0;

        if (push) begin
            ip_vec1_d = bus.req_vec1_flat[int'(grant_idx)*VEC_W +: VEC_W];
            ip_vec2_d = bus.req_vec2_flat[int'(grant_idx)*VEC_W +: VEC_W];
            wr_ptr_d  = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rsp_valid_d = N_REQ'(1) << id_mem_q[rd_ptr_q];
            rsp_res_d   = bus.ip_res;
            rd_ptr_d    = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // DRAIN completes in the first cycle it sees nothing outstanding, entry cycle included.
        case (state_q)
            ST_RUN: begin
                if (bus.flush_req_pls) state_d = ST_DRAIN;
            end
            default: begin
                if (count_q == '0) begin
                    flush_done = 1'b1;
                    state_d    = ST_RUN;
                end
            end
        endcase

        if (sw_rst) begin
            state_d     = ST_RUN;
            rr_ptr_d    = RR_RST;
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            ip_valid_d  = 1'b0;
            ip_vec1_d   = '0;
            ip_vec2_d   = '0;
            rsp_valid_d = '0;
            rsp_res_d   = '0;
            err_d       = 1'b0;
            flush_done  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_RUN;
            rr_ptr_q    <= RR_RST;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ip_valid_q  <= 1'b0;
            ip_vec1_q   <= '0;
            ip_vec2_q   <= '0;
            rsp_valid_q <= '0;
            rsp_res_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ip_valid_q  <= ip_valid_d;
            ip_vec1_q   <= ip_vec1_d;
            ip_vec2_q   <= ip_vec2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            err_q       <= err_d;
        end
    end

    // NOTE: the ID storage has no reset; an entry is only read after it was written, guarded by count.
    always_ff @(posedge clk) begin
        if (push) id_mem_q[wr_ptr_q] <= grant_idx;
    end

    assign bus.req_grant      = grant_vec;
    assign bus.ip_valid_pls   = ip_valid_q;
    assign bus.ip_vec1        = ip_vec1_q;
    assign bus.ip_vec2        = ip_vec2_q;
    assign bus.rsp_valid_pls  = rsp_valid_q;
    assign bus.rsp_res        = rsp_res_q;
    assign bus.flush_done_pls = flush_done;
    assign bus.busy           = (count_q != '0);
    assign bus.err_sticky     = err_q;
endmodule

// File: tb/tb_ga_inner_prod_arbiter.sv
// Bench for ga_inner_prod_arbiter: directed requests, a Q8.8 inner-product unit model and
// queued expected grants, responses and flush completions checked by a negedge monitor.
module tb_ga_inner_prod_arbiter;
    localparam int N_REQ   = 4;
    localparam int VEC_W   = 128;
    localparam int RES_W   = 16;
    localparam int MAX_OUT = 4;
    localparam int LANES   = 8;
    localparam int FRAC    = 8;

    // Per-requester lane values (Q8.8) and the hand-computed 8-lane dot products.
    localparam logic [15:0] VEC1_LANE [N_REQ] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    localparam logic [15:0] VEC2_LANE [N_REQ] = '{16'h0100, 16'h0100, 16'hFF80, 16'h00C0};
    localparam logic [15:0] EXP_RES   [N_REQ] = '{16'h0800, 16'h1000, 16'hF400, 16'h1800};

    typedef struct { int id; int cyc; } gnt_t;
    typedef struct { int id; logic [15:0] res; int cyc; } rsp_t;
    typedef struct { int due; logic [15:0] res; } pend_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic sw_rst = 1'b0;
    logic inject_done = 1'b0;
    int   cyc = 0;
    int   prod_lat = 3;
    int   checks = 0;
    int   failures = 0;
    int   req_target [N_REQ] = '{default: 0};
    int   gnt_seen   [N_REQ] = '{default: 0};

    gnt_t  exp_gnt[$];
    rsp_t  exp_rsp[$];
    int    exp_flush[$];
    pend_t pend[$];

    always #5 clk = ~clk;

    ga_inner_prod_arbiter_if #(.N_REQ(N_REQ), .VEC_W(VEC_W), .RES_W(RES_W)) bus ();

    ga_inner_prod_arbiter #(
        .N_REQ(N_REQ), .VEC_W(VEC_W), .RES_W(RES_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .bus(bus)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] dot(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
        logic signed [31:0] acc = 0;
        logic signed [31:0] x, y;
        for (int l = 0; l < LANES; l++) begin
            x   = signed'(a[l*16 +: 16]);
            y   = signed'(b[l*16 +: 16]);
            acc = acc + ((x * y) >>> FRAC);
        end
        return acc[15:0];
    endfunction

    // Product unit model: result appears prod_lat cycles after the issue pulse; sw_rst clears it.
    initial begin
        pend_t p;
        bus.ip_done_pls = 1'b0;
        bus.ip_res      = '0;
        forever begin
            @(negedge clk);
            if (!rstn || sw_rst) begin
                pend.delete();
                bus.ip_done_pls = 1'b0;
            end else begin
                bus.ip_done_pls = inject_done;
                if (inject_done) bus.ip_res = 16'h7777;
                if (pend.size() != 0 && pend[0].due == cyc) begin
                    p = pend.pop_front();
                    bus.ip_done_pls = 1'b1;
                    bus.ip_res      = p.res;
                end
                if (bus.ip_valid_pls) pend.push_back('{cyc + prod_lat, dot(bus.ip_vec1, bus.ip_vec2)});
            end
        end
    end

    // Monitor: every grant, response and flush completion must match the head of its queue.
    initial begin
        gnt_t g;
        rsp_t r;
        int   f;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (bus.req_grant != '0) begin
                    for (int i = 0; i < N_REQ; i++)
                        if (bus.req_grant[i] && bus.req_valid[i]) gnt_seen[i]++;
                    if (exp_gnt.size() == 0) begin
                        check("grant_unexpected", 64'(bus.req_grant), 64'd0);
                    end else begin
                        g = exp_gnt.pop_front();
                        check("grant_onehot", 64'(bus.req_grant), 64'd1 << g.id);
                        check("grant_cycle", 64'(cyc), 64'(g.cyc));
                    end
                end
                if (bus.rsp_valid_pls != '0) begin
                    if (exp_rsp.size() == 0) begin
                        check("rsp_unexpected", 64'(bus.rsp_valid_pls), 64'd0);
                    end else begin
                        r = exp_rsp.pop_front();
                        check("rsp_owner", 64'(bus.rsp_valid_pls), 64'd1 << r.id);
                        check("rsp_res", 64'(bus.rsp_res), 64'(r.res));
                        check("rsp_cycle", 64'(cyc), 64'(r.cyc));
                    end
                end
                if (bus.flush_done_pls) begin
                    if (exp_flush.size() == 0) begin
                        check("flush_done_unexpected", 64'd1, 64'd0);
                    end else begin
                        f = exp_flush.pop_front();
                        check("flush_done_cycle", 64'(cyc), 64'(f));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) bus.req_valid[i] = (gnt_seen[i] < req_target[i]);
    endtask

    task automatic req(input int i, input int n);
        req_target[i] += n;
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic expect_txn(input int id, input int gcyc, input bit with_rsp);
        exp_gnt.push_back('{id, gcyc});
        if (with_rsp) exp_rsp.push_back('{id, EXP_RES[id], gcyc + 2 + prod_lat});
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while ((exp_gnt.size() + exp_rsp.size() + exp_flush.size()) != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        check("sb_drain_left", 64'(exp_gnt.size() + exp_rsp.size() + exp_flush.size()), 64'd0);
        repeat (2) tick();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        bus.req_valid     = '0;
        bus.flush_req_pls = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_vec1_flat[i*VEC_W +: VEC_W] = {LANES{VEC1_LANE[i]}};
            bus.req_vec2_flat[i*VEC_W +: VEC_W] = {LANES{VEC2_LANE[i]}};
        end
        do_reset();

        check("rst_ip_valid", 64'(bus.ip_valid_pls), 64'd0);
        check("rst_ip_vec1", 64'(bus.ip_vec1[63:0]), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid_pls), 64'd0);
        check("rst_rsp_res", 64'(bus.rsp_res), 64'd0);
        check("rst_grant", 64'(bus.req_grant), 64'd0);
        check("rst_flush_done", 64'(bus.flush_done_pls), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_err", 64'(bus.err_sticky), 64'd0);

        // Single request from req0: 1.0 . 1.0 over 8 lanes = 8.0, response 5 cycles after grant.
        t = cyc;
        req(0, 1);
        expect_txn(0, t, 1);
        wait_idle(40);

        // All four requesting from reset: 0,1,2,3 back to back, stall at MAX_OUT, req0 again after first pop.
        do_reset();
        t = cyc;
        req(0, 2); req(1, 1); req(2, 1); req(3, 1);
        expect_txn(0, t, 1);
        expect_txn(1, t + 1, 1);
        expect_txn(2, t + 2, 1);
        expect_txn(3, t + 3, 1);
        expect_txn(0, t + 5, 1);
        wait_idle(60);

        // Only req2 and req3: alternation with the pointer wrapping past idle 0 and 1.
        do_reset();
        t = cyc;
        req(2, 2); req(3, 2);
        expect_txn(2, t, 1);
        expect_txn(3, t + 1, 1);
        expect_txn(2, t + 2, 1);
        expect_txn(3, t + 3, 1);
        wait_idle(60);

        // Longer product latency, req1 continuous: full at 4, a freed slot is usable the cycle after the pop.
        prod_lat = 4;
        t = cyc;
        req(1, 5);
        expect_txn(1, t, 1);
        expect_txn(1, t + 1, 1);
        expect_txn(1, t + 2, 1);
        expect_txn(1, t + 3, 1);
        expect_txn(1, t + 6, 1);
        wait_idle(60);

        // Flush with 3 in flight: no grants while draining, done when count reaches 0.
        prod_lat = 3;
        t = cyc;
        req(0, 1); req(1, 1); req(2, 1);
        expect_txn(2, t, 1);
        expect_txn(0, t + 1, 1);
        expect_txn(1, t + 2, 1);
        repeat (3) tick();
        bus.flush_req_pls = 1'b1;
        exp_flush.push_back(t + 7);
        tick();
        bus.flush_req_pls = 1'b0;
        req(3, 1);
        expect_txn(3, t + 8, 1);
        wait_idle(60);

        // Idle flush completes the following cycle.
        t = cyc;
        bus.flush_req_pls = 1'b1;
        exp_flush.push_back(t + 1);
        tick();
        bus.flush_req_pls = 1'b0;
        wait_idle(20);

        // sw_rst with two products in flight: everything cleared, no responses, pointer back to N_REQ-1.
        t = cyc;
        req(0, 1); req(1, 1);
        expect_txn(0, t, 0);
        expect_txn(1, t + 1, 0);
        repeat (2) tick();
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        check("swrst_busy", 64'(bus.busy), 64'd0);
        check("swrst_ip_valid", 64'(bus.ip_valid_pls), 64'd0);
        check("swrst_ip_vec1", 64'(bus.ip_vec1[63:0]), 64'd0);
        check("swrst_rsp_res", 64'(bus.rsp_res), 64'd0);
        repeat (6) tick();
        t = cyc;
        req(0, 1); req(3, 1);
        expect_txn(0, t, 1);
        expect_txn(3, t + 1, 1);
        wait_idle(40);

        // Stray done with nothing outstanding: sticky error, no response, cleared only by sw_rst.
        inject_done = 1'b1;
        tick();
        inject_done = 1'b0;
        check("err_set", 64'(bus.err_sticky), 64'd1);
        check("err_busy", 64'(bus.busy), 64'd0);
        repeat (3) tick();
        check("err_sticky_hold", 64'(bus.err_sticky), 64'd1);
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        check("err_clear_swrst", 64'(bus.err_sticky), 64'd0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
